imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 141 ++++++++++++++
 tb/tb_imem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the
// fetch unit and a loader/debug port. The loader normally has priority, and
// a starve counter forces one fetch turn after a run of loader grants that
// blocked a pending fetch. Read responses are tracked by an owner/kill
// pipeline so that a branch redirect can drop stale fetch data.
module imem_arbiter #(
  parameter int DBITS      = 32,
  parameter int ADDRBITS   = 14,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fe_req,
  input  logic [ADDRBITS-1:0] fe_addr,
  input  logic                fe_flush,
  output logic                fe_gnt,
  output logic                fe_rvalid,
  output logic [DBITS-1:0]    fe_rdata,
  input  logic                ld_req,
  input  logic                ld_we,
  input  logic [ADDRBITS-1:0] ld_addr,
  input  logic [DBITS-1:0]    ld_wdata,
  output logic                ld_gnt,
  output logic                ld_rvalid,
  output logic [DBITS-1:0]    ld_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DBITS-1:0]    mem_wdata,
  input  logic [DBITS-1:0]    mem_rdata
);

  typedef enum logic {LD_PRIO = 1'b0, FE_TURN = 1'b1} state_t;

  // One in-flight response slot: own=1 means the loader issued it.
  typedef struct packed {
    logic vld;
    logic own;
    logic kill;
  } rsp_t;

  localparam logic [2:0] STARVE_LAST = 3'(STARVE_MAX - 1);

  state_t                   state_q, state_d;
  logic [2:0]               starve_q, starve_d;
  rsp_t [MEM_LAT-1:0]       pipe_q, pipe_d;
  rsp_t                     rsp_out;

  // State register: FSM state and starve counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LD_PRIO;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next state: count loader grants that blocked a waiting fetch, and give
  // fetch exactly one turn once the run reaches STARVE_MAX grants
  always_comb begin
    state_d  = LD_PRIO;
    starve_d = starve_q;
    if (!fe_req || fe_gnt)
      starve_d = '0;
    else if (ld_gnt && starve_q != 3'h7)
      starve_d = starve_q + 3'd1;
    if (state_q == LD_PRIO && ld_gnt && fe_req && starve_q == STARVE_LAST)
      state_d = FE_TURN;
  end

  // Output decode: grants, combinational from requests and current state;
  // forced low while in reset
  always_comb begin
    fe_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        LD_PRIO: begin
          ld_gnt = ld_req;
          fe_gnt = fe_req & ~ld_req;
        end
        FE_TURN: begin
          fe_gnt = fe_req;
          ld_gnt = ld_req & ~fe_req;
        end
        default: ;
      endcase
    end
  end

  // Memory command mux; idle cycles present an all-zero command
  always_comb begin
    mem_en    = fe_gnt | ld_gnt;
    mem_we    = ld_gnt & ld_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fe_gnt)
      mem_addr = fe_addr;
    else if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  // Response tracking: new entry at stage 0, shift toward the memory's
  // return point; a flush marks every fetch entry still travelling,
  // including the one being issued in the same cycle
  always_comb begin
    pipe_d        = pipe_q;
    pipe_d[0].vld  = fe_gnt | (ld_gnt & ~ld_we);
    pipe_d[0].own  = ld_gnt;
    pipe_d[0].kill = 1'b0;
    for (int i = 1; i < MEM_LAT; i++)
      pipe_d[i] = pipe_q[i-1];
    if (fe_flush) begin
      for (int i = 0; i < MEM_LAT; i++)
        if (!pipe_d[i].own) pipe_d[i].kill = 1'b1;
    end
  end

  // Response pipeline register; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign rsp_out = pipe_q[MEM_LAT-1];

  // Response steering: last stage lines up with mem_rdata; rdata is zero
  // whenever its valid is low
  always_comb begin
    fe_rvalid = ~reset & rsp_out.vld & ~rsp_out.own & ~rsp_out.kill;
    ld_rvalid = ~reset & rsp_out.vld & rsp_out.own;
    fe_rdata  = fe_rvalid ? mem_rdata : '0;
    ld_rdata  = ld_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one instance with MEM_LAT=2 and one with
// MEM_LAT=3, each backed by a small memory model that returns read data
// MEM_LAT cycles after issue. Unwritten words hold 0xA5000000 | addr.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        fe_req, fe_flush, ld_req, ld_we;
  logic [13:0] fe_addr, ld_addr;
  logic [31:0] ld_wdata;

  logic        fe_gnt2, fe_rvalid2, ld_gnt2, ld_rvalid2, mem_en2, mem_we2;
  logic [31:0] fe_rdata2, ld_rdata2, mem_wdata2, mem_rdata2;
  logic [13:0] mem_addr2;
  logic        fe_gnt3, fe_rvalid3, ld_gnt3, ld_rvalid3, mem_en3, mem_we3;
  logic [31:0] fe_rdata3, ld_rdata3, mem_wdata3, mem_rdata3;
  logic [13:0] mem_addr3;

  int n_cmp = 0;
  int n_bad = 0;

  imem_arbiter #(.DBITS(32), .ADDRBITS(14), .MEM_LAT(2), .STARVE_MAX(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_flush(fe_flush),
    .fe_gnt(fe_gnt2), .fe_rvalid(fe_rvalid2), .fe_rdata(fe_rdata2),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt2), .ld_rvalid(ld_rvalid2), .ld_rdata(ld_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  imem_arbiter #(.DBITS(32), .ADDRBITS(14), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_flush(fe_flush),
    .fe_gnt(fe_gnt3), .fe_rvalid(fe_rvalid3), .fe_rdata(fe_rdata3),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt3), .ld_rvalid(ld_rvalid3), .ld_rdata(ld_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models
  logic [31:0] mem2 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] rd2  [0:1];
  logic [31:0] rd3  [0:2];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem2[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_en2 && mem_we2) begin
      mem2[mem_addr2[7:0]] <= mem_wdata2;
    end
    rd2[0] <= mem2[mem_addr2[7:0]];
    rd2[1] <= rd2[0];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_en3 && mem_we3) begin
      mem3[mem_addr3[7:0]] <= mem_wdata3;
    end
    rd3[0] <= mem3[mem_addr3[7:0]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign mem_rdata2 = rd2[1];
  assign mem_rdata3 = rd3[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fe_req = 0; ld_req = 0; ld_we = 0; fe_flush = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1; fe_req = 1; ld_req = 1; ld_we = 1;
    fe_addr = 14'h011; ld_addr = 14'h022; ld_wdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({fe_gnt2, ld_gnt2, mem_en2, mem_we2, fe_rvalid2, ld_rvalid2} !== 6'b0) begin
        n_bad++; $display("FAIL reset_ctl2 c=%0d got=%b exp=000000", c,
          {fe_gnt2, ld_gnt2, mem_en2, mem_we2, fe_rvalid2, ld_rvalid2});
      end
      n_cmp++;
      if ({mem_addr2, mem_wdata2, fe_rdata2, ld_rdata2} !== '0) begin
        n_bad++; $display("FAIL reset_data2 c=%0d addr=%h wdata=%h fe=%h ld=%h exp=0",
          c, mem_addr2, mem_wdata2, fe_rdata2, ld_rdata2);
      end
      n_cmp++;
      if ({fe_gnt3, ld_gnt3, mem_en3, mem_we3, fe_rvalid3, ld_rvalid3} !== 6'b0) begin
        n_bad++; $display("FAIL reset_ctl3 c=%0d got=%b exp=000000", c,
          {fe_gnt3, ld_gnt3, mem_en3, mem_we3, fe_rvalid3, ld_rvalid3});
      end
      step();
    end
    reset = 0;
    idle(4);
  endtask

  task automatic test_fetch_stream();
    logic e_g, e_v;
    logic [31:0] e_d;
    for (int c = 0; c < 6; c++) begin
      fe_req = (c < 3); fe_addr = 14'h010;
      e_g = (c < 3);
      e_v = (c >= 2 && c <= 4);
      e_d = e_v ? 32'hA500_0010 : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (fe_gnt2 !== e_g || mem_en2 !== e_g) begin
        n_bad++; $display("FAIL fetch_gnt c=%0d got=%b/%b exp=%b", c, fe_gnt2, mem_en2, e_g);
      end
      n_cmp++;
      if (fe_rvalid2 !== e_v || fe_rdata2 !== e_d) begin
        n_bad++; $display("FAIL fetch_rsp c=%0d got=%b/%h exp=%b/%h", c, fe_rvalid2, fe_rdata2, e_v, e_d);
      end
      if (c < 3) begin
        n_cmp++;
        if (mem_addr2 !== 14'h010) begin
          n_bad++; $display("FAIL fetch_addr c=%0d got=%h exp=010", c, mem_addr2);
        end
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_starve();
    int nl, nf;
    logic e_f;
    nl = 0; nf = 0;
    for (int c = 0; c < 12; c++) begin
      fe_req = 1; ld_req = 1; ld_we = 0;
      fe_addr = 14'h031; ld_addr = 14'h030;
      e_f = (c == 4 || c == 9);
      @(negedge clk);
      nl += int'(ld_gnt2); nf += int'(fe_gnt2);
      n_cmp++;
      if (fe_gnt2 !== e_f || ld_gnt2 !== !e_f) begin
        n_bad++; $display("FAIL starve_pat c=%0d got fe=%b ld=%b exp fe=%b", c, fe_gnt2, ld_gnt2, e_f);
      end
      if (e_f) begin
        n_cmp++;
        if (mem_addr2 !== 14'h031 || mem_we2 !== 1'b0) begin
          n_bad++; $display("FAIL starve_addr c=%0d got=%h/%b exp=031/0", c, mem_addr2, mem_we2);
        end
      end
      step();
    end
    n_cmp++;
    if (nl != 10 || nf != 2) begin
      n_bad++; $display("FAIL starve_cnt got ld=%0d fe=%0d exp ld=10 fe=2", nl, nf);
    end
    idle(4);
  endtask

  task automatic test_write_then_fetch();
    logic e_v;
    logic [31:0] e_d;
    for (int c = 0; c < 5; c++) begin
      ld_req = (c == 0); ld_we = (c == 0); ld_addr = 14'h020; ld_wdata = 32'hDEAD_BEEF;
      fe_req = (c == 1); fe_addr = 14'h020;
      e_v = (c == 3);
      e_d = e_v ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (mem_we2 !== (c == 0)) begin
        n_bad++; $display("FAIL wr_we c=%0d got=%b", c, mem_we2);
      end
      if (c == 0) begin
        n_cmp++;
        if (ld_gnt2 !== 1'b1 || mem_addr2 !== 14'h020 || mem_wdata2 !== 32'hDEAD_BEEF) begin
          n_bad++; $display("FAIL wr_cmd got gnt=%b addr=%h wdata=%h exp 1/020/deadbeef",
            ld_gnt2, mem_addr2, mem_wdata2);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (fe_gnt2 !== 1'b1 || mem_wdata2 !== 32'h0) begin
          n_bad++; $display("FAIL wr_fetch_gnt got gnt=%b wdata=%h exp 1/0", fe_gnt2, mem_wdata2);
        end
      end
      n_cmp++;
      if (ld_rvalid2 !== 1'b0) begin
        n_bad++; $display("FAIL wr_no_rvalid c=%0d got=%b exp=0", c, ld_rvalid2);
      end
      n_cmp++;
      if (fe_rvalid2 !== e_v || fe_rdata2 !== e_d) begin
        n_bad++; $display("FAIL wr_readback c=%0d got=%b/%h exp=%b/%h", c, fe_rvalid2, fe_rdata2, e_v, e_d);
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_flush();
    logic e_v;
    logic [31:0] e_d;
    for (int c = 0; c < 8; c++) begin
      fe_req = (c < 3); fe_addr = 14'h040 + 14'(c); fe_flush = (c == 1);
      e_v = (c == 5);
      e_d = e_v ? 32'hA500_0042 : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (fe_gnt3 !== (c < 3)) begin
        n_bad++; $display("FAIL flush_gnt c=%0d got=%b", c, fe_gnt3);
      end
      n_cmp++;
      if (fe_rvalid3 !== e_v || fe_rdata3 !== e_d) begin
        n_bad++; $display("FAIL flush_rsp c=%0d got=%b/%h exp=%b/%h", c, fe_rvalid3, fe_rdata3, e_v, e_d);
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_flush_loader();
    logic e_l, e_f;
    logic [31:0] e_ld, e_fd;
    for (int c = 0; c < 7; c++) begin
      ld_req = (c == 0); ld_we = 0; ld_addr = 14'h050;
      fe_req = (c == 1 || c == 2); fe_addr = (c == 1) ? 14'h051 : 14'h052;
      fe_flush = (c == 1);
      e_l = (c == 2); e_ld = e_l ? 32'hA500_0050 : 32'h0;
      e_f = (c == 4); e_fd = e_f ? 32'hA500_0052 : 32'h0;
      @(negedge clk);
      n_cmp++;
      if (ld_rvalid2 !== e_l || ld_rdata2 !== e_ld) begin
        n_bad++; $display("FAIL flush_ld_rsp c=%0d got=%b/%h exp=%b/%h", c, ld_rvalid2, ld_rdata2, e_l, e_ld);
      end
      n_cmp++;
      if (fe_rvalid2 !== e_f || fe_rdata2 !== e_fd) begin
        n_bad++; $display("FAIL flush_fe_rsp c=%0d got=%b/%h exp=%b/%h", c, fe_rvalid2, fe_rdata2, e_f, e_fd);
      end
      if (c == 1) begin
        n_cmp++;
        if (fe_gnt2 !== 1'b1) begin
          n_bad++; $display("FAIL flush_fe_gnt got=%b exp=1", fe_gnt2);
        end
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_reset_inflight();
    logic e_f;
    // Fetch granted, then reset the next cycle: its data must never surface
    for (int c = 0; c < 6; c++) begin
      reset  = (c == 1);
      fe_req = (c <= 1); ld_req = (c == 1); ld_we = 0;
      fe_addr = 14'h060; ld_addr = 14'h061;
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (fe_gnt2 !== 1'b1) begin
          n_bad++; $display("FAIL rst_fe_gnt got=%b exp=1", fe_gnt2);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if ({fe_gnt2, ld_gnt2, mem_en2} !== 3'b0 || mem_addr2 !== 14'h0) begin
          n_bad++; $display("FAIL rst_gate got=%b addr=%h exp=000/0", {fe_gnt2, ld_gnt2, mem_en2}, mem_addr2);
        end
      end
      n_cmp++;
      if (fe_rvalid2 !== 1'b0 || ld_rvalid2 !== 1'b0) begin
        n_bad++; $display("FAIL rst_no_rvalid c=%0d got=%b/%b exp=0/0", c, fe_rvalid2, ld_rvalid2);
      end
      step();
    end
    // Push into FE_TURN with a nonzero counter, reset, then the full
    // L,L,L,L,F sequence must restart from scratch
    for (int c = 0; c < 10; c++) begin
      reset = (c == 4);
      fe_req = 1; ld_req = 1; ld_we = 0;
      fe_addr = 14'h070; ld_addr = 14'h071;
      e_f = (c == 9);
      @(negedge clk);
      n_cmp++;
      if (c == 4) begin
        if (fe_gnt2 !== 1'b0 || ld_gnt2 !== 1'b0) begin
          n_bad++; $display("FAIL rst_fsm_gate got fe=%b ld=%b exp 0/0", fe_gnt2, ld_gnt2);
        end
      end else if (fe_gnt2 !== e_f || ld_gnt2 !== !e_f) begin
        n_bad++; $display("FAIL rst_fsm_pat c=%0d got fe=%b ld=%b exp fe=%b", c, fe_gnt2, ld_gnt2, e_f);
      end
      step();
    end
    reset = 0;
    idle(4);
  endtask

  initial begin
    reset = 1; fe_req = 0; fe_flush = 0; ld_req = 0; ld_we = 0;
    fe_addr = '0; ld_addr = '0; ld_wdata = '0;
    step();
    test_reset();
    test_fetch_stream();
    test_starve();
    test_write_then_fetch();
    test_flush();
    test_flush_loader();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
